fpu_arbiter: RTL
================

FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter LATENCY, default 2, fixed cycle count from fpu_valid sampled to fpu_result valid on the shared unit.
REQ-002 Parameter OPW, default 3, width of the operation code.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0_valid  input  1  requester 0 presents an operation.
REQ-006 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-007 req0_op  input  OPW  requester 0 opcode.
REQ-008 req0_a, req0_b  input  32 each  requester 0 IEEE-754 single operands.
REQ-009 req1_valid, req1_ready, req1_op, req1_a, req1_b  same as REQ-005..008, requester 1.
REQ-010 fpu_valid  output  1  issue strobe to shared FPU unit.
REQ-011 fpu_op  output  OPW  issued opcode.
REQ-012 fpu_a, fpu_b  output  32 each  issued operands.
REQ-013 fpu_result  input  32  shared unit result, LATENCY cycles after issue.
REQ-014 fpu_ovf  input  1  shared unit overflow flag, aligned with fpu_result.
REQ-015 res0_valid  output  1  one-cycle result pulse to requester 0.
REQ-016 res0_data  output  32  result for requester 0.
REQ-017 res0_ovf  output  1  overflow for requester 0.
REQ-018 res1_valid, res1_data, res1_ovf  same as REQ-015..017, requester 1.

Function
REQ-019 Handshake: an operation transfers on a rising edge where reqN_valid and reqN_ready are both 1; reqN_ready is combinational from valids and grant state.
REQ-020 At most one of req0_ready, req1_ready SHALL be 1 in any cycle; reqN_ready SHALL be 0 when reqN_valid is 0 or rst is 1.
REQ-021 Only one requester valid: that requester is granted.
REQ-022 Both valid: grant the requester not granted by the most recent accepted transfer (round-robin via 1-bit last_grant); after reset last_grant = 1, so requester 0 wins the first contention.
REQ-023 last_grant SHALL update only on an accepted transfer; idle cycles leave it unchanged.
REQ-024 Issue register: transfer at edge T drives fpu_valid=1 with captured op/a/b during cycle T+1; no transfer -> fpu_valid=0, fpu_op/a/b hold last values.
REQ-025 Throughput: one transfer per cycle sustained; no bubbles inserted between back-to-back grants.
REQ-026 Tag pipeline: a LATENCY-deep shift register of {valid, id} SHALL track each issue; entry exits when fpu_result for that issue is valid.
REQ-027 Result register: fpu_result/fpu_ovf sampled with exiting tag drive resN_valid=1, resN_data, resN_ovf in cycle T+2+LATENCY (T+4 for default) for the requester id N.
REQ-028 At most one of res0_valid, res1_valid SHALL be 1 per cycle; non-addressed requester's data/ovf hold previous values.
REQ-029 Results SHALL return in issue order; no backpressure on results — requesters capture on the pulse.
REQ-030 Operand/opcode values SHALL pass unmodified; the arbiter performs no arithmetic.

Reset
REQ-031 With rst=1 at an edge: fpu_valid=0, res0_valid=0, res1_valid=0, all tag valids cleared, last_grant=1, fpu_op/a/b and resN_data=0, resN_ovf=0.
REQ-032 Reset mid-operation: in-flight operations discarded; no resN_valid SHALL pulse for any operation accepted before reset, even if fpu_result arrives after reset deasserts.
REQ-033 reqN_ready=0 throughout reset; first acceptance possible in the first cycle with rst=0.

Verification (bench models shared FPU as LATENCY-cycle delayed adder)
REQ-034 Single op: req0 op=0, a=0x3F800000, b=0x40000000 accepted at T -> fpu_valid at T+1, res0_valid=1, res0_data=0x40400000 at T+4, res1_valid=0 throughout.
REQ-035 Contention: both valid continuously for 4 cycles after reset -> grants 0,1,0,1; res pulses alternate 0,1,0,1 on consecutive cycles.
REQ-036 Fairness after idle: req1 alone accepted, idle 3 cycles, then both valid -> req0 granted first.
REQ-037 Reset mid-flight: two ops accepted at T, T+1, rst=1 at T+2 for one cycle -> no res0_valid/res1_valid pulse through T+8; fpu_valid=0 at T+3.
REQ-038 Overflow: req1 a=0x7F7FFFFF, b=0x7F7FFFFF, model flags ovf -> res1_valid=1, res1_ovf=1, res1_data=0x7F800000 at T+4.
REQ-039 Parameter sweep: LATENCY=1 and 4 -> result pulse at T+3 and T+6 respectively, order preserved under full-rate traffic.

Source files
------------

// File: rtl/fpu_arbiter.sv
`default_nettype none
// ============================================================================
// fpu_arbiter: round-robin 2:1 front end for a shared fixed-latency FPU that
// steers each returning result to the requester that issued it.
// Revision: 1.0
// ============================================================================
module fpu_arbiter #(
  parameter int LATENCY = 2,
  parameter int OPW     = 3
) (
  input  logic           clk,
  input  logic           rst,

  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [31:0]    req0_a,
  input  logic [31:0]    req0_b,

  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [31:0]    req1_a,
  input  logic [31:0]    req1_b,

  output logic           fpu_valid,
  output logic [OPW-1:0] fpu_op,
  output logic [31:0]    fpu_a,
  output logic [31:0]    fpu_b,
  input  logic [31:0]    fpu_result,
  input  logic           fpu_ovf,

  output logic           res0_valid,
  output logic [31:0]    res0_data,
  output logic           res0_ovf,

  output logic           res1_valid,
  output logic [31:0]    res1_data,
  output logic           res1_ovf
);

  logic               w_grant0;
  logic               w_grant1;
  logic               w_exit_vld;
  logic               w_exit_id;

  logic               last_grant_q, last_grant_d;
  logic               fpu_valid_q,  fpu_valid_d;
  logic               fpu_id_q,     fpu_id_d;
  logic [OPW-1:0]     fpu_op_q,     fpu_op_d;
  logic [31:0]        fpu_a_q,      fpu_a_d;
  logic [31:0]        fpu_b_q,      fpu_b_d;

  logic [LATENCY-1:0] tag_vld_q,    tag_vld_d;
  logic [LATENCY-1:0] tag_id_q,     tag_id_d;

  logic               res0_valid_q, res0_valid_d;
  logic [31:0]        res0_data_q,  res0_data_d;
  logic               res0_ovf_q,   res0_ovf_d;
  logic               res1_valid_q, res1_valid_d;
  logic [31:0]        res1_data_q,  res1_data_d;
  logic               res1_ovf_q,   res1_ovf_d;

  // last_grant_q == 1 means requester 1 won most recently, so 0 wins a tie.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        w_grant0 = last_grant_q;
        w_grant1 = !last_grant_q;
      end else begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  always_comb begin
    last_grant_d = last_grant_q;
    fpu_valid_d  = w_grant0 || w_grant1;
    fpu_id_d     = w_grant1;
    fpu_op_d     = fpu_op_q;
    fpu_a_d      = fpu_a_q;
    fpu_b_d      = fpu_b_q;
    if (w_grant0) begin
      last_grant_d = 1'b0;
      fpu_op_d     = req0_op;
      fpu_a_d      = req0_a;
      fpu_b_d      = req0_b;
    end else if (w_grant1) begin
      last_grant_d = 1'b1;
      fpu_op_d     = req1_op;
      fpu_a_d      = req1_a;
      fpu_b_d      = req1_b;
    end
  end

  // The tag leaving the last stage lines up with fpu_result for that issue.
  generate
    if (LATENCY == 1) begin : g_tag_single
      assign tag_vld_d = fpu_valid_q;
      assign tag_id_d  = fpu_id_q;
    end else begin : g_tag_shift
      assign tag_vld_d = {tag_vld_q[LATENCY-2:0], fpu_valid_q};
      assign tag_id_d  = {tag_id_q[LATENCY-2:0],  fpu_id_q};
    end
  endgenerate

  assign w_exit_vld = tag_vld_q[LATENCY-1];
  assign w_exit_id  = tag_id_q[LATENCY-1];

  always_comb begin
    res0_valid_d = w_exit_vld && !w_exit_id;
    res1_valid_d = w_exit_vld && w_exit_id;
    res0_data_d  = res0_data_q;
    res0_ovf_d   = res0_ovf_q;
    res1_data_d  = res1_data_q;
    res1_ovf_d   = res1_ovf_q;
    if (res0_valid_d) begin
      res0_data_d = fpu_result;
      res0_ovf_d  = fpu_ovf;
    end
    if (res1_valid_d) begin
      res1_data_d = fpu_result;
      res1_ovf_d  = fpu_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      fpu_valid_q  <= 1'b0;
      fpu_id_q     <= 1'b0;
      fpu_op_q     <= '0;
      fpu_a_q      <= '0;
      fpu_b_q      <= '0;
      tag_vld_q    <= '0;
      tag_id_q     <= '0;
      res0_valid_q <= 1'b0;
      res0_data_q  <= '0;
      res0_ovf_q   <= 1'b0;
      res1_valid_q <= 1'b0;
      res1_data_q  <= '0;
      res1_ovf_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      fpu_valid_q  <= fpu_valid_d;
      fpu_id_q     <= fpu_id_d;
      fpu_op_q     <= fpu_op_d;
      fpu_a_q      <= fpu_a_d;
      fpu_b_q      <= fpu_b_d;
      tag_vld_q    <= tag_vld_d;
      tag_id_q     <= tag_id_d;
      res0_valid_q <= res0_valid_d;
      res0_data_q  <= res0_data_d;
      res0_ovf_q   <= res0_ovf_d;
      res1_valid_q <= res1_valid_d;
      res1_data_q  <= res1_data_d;
      res1_ovf_q   <= res1_ovf_d;
    end
  end

  assign fpu_valid  = fpu_valid_q;
  assign fpu_op     = fpu_op_q;
  assign fpu_a      = fpu_a_q;
  assign fpu_b      = fpu_b_q;
  assign res0_valid = res0_valid_q;
  assign res0_data  = res0_data_q;
  assign res0_ovf   = res0_ovf_q;
  assign res1_valid = res1_valid_q;
  assign res1_data  = res1_data_q;
  assign res1_ovf   = res1_ovf_q;

endmodule
`default_nettype wire
